// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and EX-stall hold.
// Optional IDEX_PERF_EN adds saturating bubble/flush event counters.
module idex_pipe_reg #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hazard,
  input  logic           flush,
  input  logic           ex_stall,
  input  logic           id_valid,
  input  logic           id_RegWrite,
  input  logic           id_MemtoReg,
  input  logic           id_MemRead,
  input  logic           id_MemWrite,
  input  logic           id_ALUSrc,
  input  logic           id_RegDst,
  input  logic [OPW-1:0] id_ALUOp,
  input  logic [DW-1:0]  id_rd1,
  input  logic [DW-1:0]  id_rd2,
  input  logic [DW-1:0]  id_imm,
  input  logic [DW-1:0]  id_pc4,
  input  logic [AW-1:0]  id_Rs,
  input  logic [AW-1:0]  id_Rt,
  input  logic [AW-1:0]  id_Rd,
  output logic           ex_valid,
  output logic           ex_RegWrite,
  output logic           ex_MemtoReg,
  output logic           ex_MemWrite,
  output logic           ex_ALUSrc,
  output logic           ex_RegDst,
  output logic [OPW-1:0] ex_ALUOp,
  output logic [DW-1:0]  ex_rd1,
  output logic [DW-1:0]  ex_rd2,
  output logic [DW-1:0]  ex_imm,
  output logic [DW-1:0]  ex_pc4,
  output logic [AW-1:0]  ex_Rs,
  output logic [AW-1:0]  ex_Rd,
  output logic           IDEX_mem_Read,
  output logic [AW-1:0]  IDEX_Rt,
  output logic           ex_bubble
`ifdef IDEX_PERF_EN
  ,
  output logic [15:0]    bubble_cnt,
  output logic [15:0]    flush_cnt
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_VALID, S_BUBBLE, S_HOLD} state_t;

  state_t r_state, r_saved;
  state_t w_next, w_saved_next, w_cur;

  logic           r_RegWrite, r_MemtoReg, r_MemRead, r_MemWrite, r_ALUSrc, r_RegDst;
  logic [OPW-1:0] r_ALUOp;
  logic [DW-1:0]  r_rd1, r_rd2, r_imm, r_pc4;
  logic [AW-1:0]  r_Rs, r_Rt, r_Rd;
  logic           w_kill_ctrl;

  assign w_kill_ctrl = flush | ~hazard;

  always_comb begin
    w_next       = r_state;
    w_saved_next = r_saved;
    if (ex_stall) begin
      w_next = S_HOLD;
      if (r_state != S_HOLD) w_saved_next = r_state;
    end else if (flush) begin
      w_next = S_EMPTY;
    end else if (!hazard) begin
      w_next = S_BUBBLE;
    end else begin
      w_next = id_valid ? S_VALID : S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_saved <= S_EMPTY;
    end else begin
      r_state <= w_next;
      r_saved <= w_saved_next;
    end
  end

  // Data/specifier fields load even on flush or bubble; only control is squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_RegWrite <= 1'b0;
      r_MemtoReg <= 1'b0;
      r_MemRead  <= 1'b0;
      r_MemWrite <= 1'b0;
      r_ALUSrc   <= 1'b0;
      r_RegDst   <= 1'b0;
      r_ALUOp    <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
      r_Rs       <= '0;
      r_Rt       <= '0;
      r_Rd       <= '0;
    end else if (!ex_stall) begin
      r_RegWrite <= id_RegWrite & ~w_kill_ctrl;
      r_MemtoReg <= id_MemtoReg & ~w_kill_ctrl;
      r_MemRead  <= id_MemRead  & ~w_kill_ctrl;
      r_MemWrite <= id_MemWrite & ~w_kill_ctrl;
      r_ALUSrc   <= id_ALUSrc   & ~w_kill_ctrl;
      r_RegDst   <= id_RegDst   & ~w_kill_ctrl;
      r_ALUOp    <= w_kill_ctrl ? '0 : id_ALUOp;
      r_rd1      <= id_rd1;
      r_rd2      <= id_rd2;
      r_imm      <= id_imm;
      r_pc4      <= id_pc4;
      r_Rs       <= id_Rs;
      r_Rt       <= id_Rt;
      r_Rd       <= id_Rd;
    end
  end

  assign w_cur         = (r_state == S_HOLD) ? r_saved : r_state;
  assign ex_valid      = (w_cur == S_VALID);
  assign ex_bubble     = (w_cur == S_BUBBLE);
  assign ex_RegWrite   = r_RegWrite;
  assign ex_MemtoReg   = r_MemtoReg;
  assign ex_MemWrite   = r_MemWrite;
  assign ex_ALUSrc     = r_ALUSrc;
  assign ex_RegDst     = r_RegDst;
  assign ex_ALUOp      = r_ALUOp;
  assign ex_rd1        = r_rd1;
  assign ex_rd2        = r_rd2;
  assign ex_imm        = r_imm;
  assign ex_pc4        = r_pc4;
  assign ex_Rs         = r_Rs;
  assign ex_Rd         = r_Rd;
  assign IDEX_mem_Read = r_MemRead;
  assign IDEX_Rt       = r_Rt;

`ifdef IDEX_PERF_EN
  logic [15:0] r_bubble_cnt, r_flush_cnt;
  logic        w_bubble_ev, w_flush_ev;

  assign w_bubble_ev = ~ex_stall & ~flush & ~hazard;
  assign w_flush_ev  = ~ex_stall & flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_bubble_ev && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 16'd1;
      if (w_flush_ev && r_flush_cnt != '1)   r_flush_cnt  <= r_flush_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule
